// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache.
// Provides the controller state encoding and the address field width helpers
// used to split a word address into tag / index / offset.
package dcache_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2
    } state_e;

    function automatic int off_bits(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_bits(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_bits(input int lines, input int words);
        return ADDR_W - $clog2(lines) - $clog2(words);
    endfunction

endpackage

// File: rtl/dcache_line_ram.sv
// Valid/tag/data storage for the data cache, one line per index.
// Combinational read of the indexed line (valid, tag, one word); synchronous
// single-word write, tag write that also sets valid, and a valid clear on rst_i.
// Ports: clk_i/rst_i; idx_i selects the line for both read and write;
//        rd_off_i/rd_*_o read port; wr_en_i/wr_off_i/wr_data_i word write;
//        tag_wr_i/tag_i commit tag + valid; inval_i clears the line's valid.
module dcache_line_ram
    import dcache_pkg::*;
#(
    parameter int LINES = 8,
    parameter int WORDS = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [idx_bits(LINES)-1:0]      idx_i,
    input  logic [off_bits(WORDS)-1:0]      rd_off_i,
    output logic                            rd_valid_o,
    output logic [tag_bits(LINES,WORDS)-1:0] rd_tag_o,
    output logic [DATA_W-1:0]               rd_data_o,
    input  logic                            wr_en_i,
    input  logic [off_bits(WORDS)-1:0]      wr_off_i,
    input  logic [DATA_W-1:0]               wr_data_i,
    input  logic                            tag_wr_i,
    input  logic [tag_bits(LINES,WORDS)-1:0] tag_i,
    input  logic                            inval_i
);

    localparam int TAG_W = tag_bits(LINES, WORDS);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES][WORDS];

    // Only valid bits are reset; tag/data contents are don't-care while invalid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (tag_wr_i) begin
            valid_q[idx_i] <= 1'b1;
        end else if (inval_i) begin
            valid_q[idx_i] <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            data_q[idx_i][wr_off_i] <= wr_data_i;
        end
        if (tag_wr_i) begin
            tag_q[idx_i] <= tag_i;
        end
    end

    assign rd_valid_o = valid_q[idx_i];
    assign rd_tag_o   = tag_q[idx_i];
    assign rd_data_o  = data_q[idx_i][rd_off_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read hits return data combinationally with hit_out=1; misses fill the whole
// line from main memory (WORDS acks) and hit on the following IDLE cycle;
// stores always write through and complete with hit_out=1 in the ack cycle.
// Ports: clk/rst; addr_in/wdata_in/MemRead_in/MemWrite_in from EX/MEM;
//        hit_out/rdata_out back to the pipeline; mem_* to main data memory.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES = 8,
    parameter int WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    output logic              hit_out,
    output logic [DATA_W-1:0] rdata_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int OFF_W = off_bits(WORDS);
    localparam int IDX_W = idx_bits(LINES);
    localparam int TAG_W = tag_bits(LINES, WORDS);
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

    state_e           state_q, state_d;
    logic [OFF_W-1:0] cnt_q, cnt_d;

    logic [OFF_W-1:0]  off_f;
    logic [IDX_W-1:0]  idx_f;
    logic [TAG_W-1:0]  tag_f;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              lu_hit;

    logic              wr_en;
    logic [OFF_W-1:0]  wr_off;
    logic [DATA_W-1:0] wr_data;
    logic              tag_wr;
    logic              inval;

    assign off_f = addr_in[OFF_W-1:0];
    assign idx_f = addr_in[OFF_W +: IDX_W];
    assign tag_f = addr_in[ADDR_W-1 -: TAG_W];

    dcache_line_ram #(
        .LINES (LINES),
        .WORDS (WORDS)
    ) u_line_ram (
        .clk_i      (clk),
        .rst_i      (rst),
        .idx_i      (idx_f),
        .rd_off_i   (off_f),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (wr_en),
        .wr_off_i   (wr_off),
        .wr_data_i  (wr_data),
        .tag_wr_i   (tag_wr),
        .tag_i      (tag_f),
        .inval_i    (inval)
    );

    assign lu_hit = rd_valid && (rd_tag == tag_f);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hit_out   = 1'b0;
        rdata_out = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wr_en     = 1'b0;
        wr_off    = off_f;
        wr_data   = wdata_in;
        tag_wr    = 1'b0;
        inval     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (MemWrite_in) begin
                    state_d = S_WRITE;
                end else if (MemRead_in) begin
                    if (lu_hit) begin
                        hit_out   = 1'b1;
                        rdata_out = rd_data;
                    end else begin
                        // Drop the old line now so a refill in progress can
                        // never be mistaken for valid data under the old tag.
                        inval   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_FILL;
                    end
                end else begin
                    hit_out = 1'b1;
                end
            end

            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {tag_f, idx_f, cnt_q};
                if (mem_ack) begin
                    wr_en   = 1'b1;
                    wr_off  = cnt_q;
                    wr_data = mem_rdata;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        tag_wr  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            S_WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_in;
                mem_wdata = wdata_in;
                if (mem_ack) begin
                    hit_out = 1'b1;
                    // No allocate: only refresh a line that already holds it.
                    wr_en   = lu_hit;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a behavioural main-memory responder.
// Memory word at address a holds a ^ 0x00E0 until written; acks follow a
// programmable number of wait cycles while mem_req is high.
module tb_dcache_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] addr_in;
    logic [15:0] wdata_in;
    logic        MemRead_in;
    logic        MemWrite_in;
    logic        hit_out;
    logic [15:0] rdata_out;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem [0:1023];
    logic [15:0] rd_log[$];
    int          n_wr_acks;
    int          ack_wait;
    int          wcnt;

    dcache_ctrl #(.LINES(8), .WORDS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .addr_in     (addr_in),
        .wdata_in    (wdata_in),
        .MemRead_in  (MemRead_in),
        .MemWrite_in (MemWrite_in),
        .hit_out     (hit_out),
        .rdata_out   (rdata_out),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory responder: drives ack/rdata on negedge so they are stable at posedge.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        wcnt      = 0;
        n_wr_acks = 0;
        ack_wait  = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i) ^ 16'h00E0;
        forever begin
            @(negedge clk);
            if (mem_req && wcnt >= ack_wait) begin
                mem_ack = 1'b1;
                wcnt    = 0;
                if (mem_we) begin
                    mem[mem_addr[9:0]] = mem_wdata;
                    mem_rdata = '0;
                    n_wr_acks++;
                end else begin
                    mem_rdata = mem[mem_addr[9:0]];
                    rd_log.push_back(mem_addr);
                end
            end else begin
                mem_ack = 1'b0;
                if (mem_req) wcnt++;
                else wcnt = 0;
            end
        end
    end

    // Apply a request just after a posedge and run it until hit_out is seen.
    task automatic access(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] wd, output int low,
                          output logic [15:0] data, output logic saw_req,
                          output logic saw_we);
        logic got;
        addr_in     = a;
        wdata_in    = wd;
        MemRead_in  = rd;
        MemWrite_in = wr;
        low = 0; data = '0; saw_req = 1'b0; saw_we = 1'b0; got = 1'b0;
        rd_log.delete();
        n_wr_acks = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk); #1;
            if (mem_req) saw_req = 1'b1;
            if (mem_we)  saw_we  = 1'b1;
            if (hit_out) begin
                data = rdata_out;
                got  = 1'b1;
                break;
            end
            low++;
        end
        chk("access_completes", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        MemRead_in  = 1'b0;
        MemWrite_in = 1'b0;
    endtask

    task automatic check_fill(input string tag, input logic [15:0] base);
        chk({tag, "_nacks"}, rd_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < rd_log.size()) chk({tag, "_addr"}, {16'd0, rd_log[i]}, {16'd0, base + 16'(i)});
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    int          low;
    logic [15:0] data;
    logic        sreq;
    logic        swe;

    initial begin
        rst = 1'b1; addr_in = '0; wdata_in = '0; MemRead_in = 1'b0; MemWrite_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hit",       {31'd0, hit_out}, 32'd1);
        chk("rst_mem_req",   {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we",    {31'd0, mem_we},  32'd0);
        chk("rst_mem_addr",  {16'd0, mem_addr},  32'd0);
        chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        chk("rst_rdata",     {16'd0, rdata_out}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Cold miss and fill of line 0x0040.
        ack_wait = 0;
        access(1'b1, 1'b0, 16'h0040, 16'h0, low, data, sreq, swe);
        chk("fill40_low", low, 5);
        chk("fill40_data", {16'd0, data}, 32'h00A0);
        check_fill("fill40", 16'h0040);

        access(1'b1, 1'b0, 16'h0042, 16'h0, low, data, sreq, swe);
        chk("hit42_low", low, 0);
        chk("hit42_data", {16'd0, data}, 32'h00A2);
        chk("hit42_noreq", {31'd0, sreq}, 32'd0);

        // Write-through hit with slow memory.
        ack_wait = 2;
        access(1'b0, 1'b1, 16'h0041, 16'h1234, low, data, sreq, swe);
        chk("wr41_low", low, 3);
        chk("wr41_we", {31'd0, swe}, 32'd1);
        chk("wr41_nwr", n_wr_acks, 1);
        chk("wr41_mem", {16'd0, mem[16'h041]}, 32'h1234);
        ack_wait = 0;
        access(1'b1, 1'b0, 16'h0041, 16'h0, low, data, sreq, swe);
        chk("hit41_low", low, 0);
        chk("hit41_data", {16'd0, data}, 32'h1234);
        chk("hit41_noreq", {31'd0, sreq}, 32'd0);

        // Write miss: no allocate, then read fills.
        access(1'b0, 1'b1, 16'h0100, 16'hBEEF, low, data, sreq, swe);
        chk("wr100_nfill", rd_log.size(), 0);
        chk("wr100_mem", {16'd0, mem[16'h100]}, 32'hBEEF);
        access(1'b1, 1'b0, 16'h0100, 16'h0, low, data, sreq, swe);
        chk("rd100_low", low, 5);
        chk("rd100_data", {16'd0, data}, 32'hBEEF);
        check_fill("fill100", 16'h0100);

        // Conflict: same index, different tag, from a cold cache.
        do_reset();
        access(1'b1, 1'b0, 16'h0040, 16'h0, low, data, sreq, swe);
        chk("cf1_low", low, 5);
        chk("cf1_data", {16'd0, data}, 32'h00A0);
        check_fill("cf1", 16'h0040);
        access(1'b1, 1'b0, 16'h0061, 16'h0, low, data, sreq, swe);
        chk("cf2_low", low, 5);
        chk("cf2_data", {16'd0, data}, 32'h0081);
        check_fill("cf2", 16'h0060);
        access(1'b1, 1'b0, 16'h0043, 16'h0, low, data, sreq, swe);
        chk("cf3_low", low, 5);
        chk("cf3_data", {16'd0, data}, 32'h00A3);
        check_fill("cf3", 16'h0040);

        // Reset in the middle of a fill of 0x0080.
        addr_in = 16'h0080; MemRead_in = 1'b1; MemWrite_in = 1'b0;
        rd_log.delete();
        for (int c = 0; c < 20 && rd_log.size() < 2; c++) begin
            @(negedge clk); #1;
        end
        chk("mid_two_acks", rd_log.size(), 2);
        @(posedge clk); #1;
        rst = 1'b1; MemRead_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        chk("mid_req_drop", {31'd0, mem_req}, 32'd0);
        chk("mid_idle_hit", {31'd0, hit_out}, 32'd1);
        @(posedge clk); #1;
        access(1'b1, 1'b0, 16'h0080, 16'h0, low, data, sreq, swe);
        chk("rd80_low", low, 5);
        chk("rd80_data", {16'd0, data}, 32'h0060);
        check_fill("fill80", 16'h0080);

        // Read and write together behave as a write.
        access(1'b1, 1'b1, 16'h0010, 16'h5555, low, data, sreq, swe);
        chk("both_we", {31'd0, swe}, 32'd1);
        chk("both_nfill", rd_log.size(), 0);
        chk("both_nwr", n_wr_acks, 1);
        chk("both_mem", {16'd0, mem[16'h010]}, 32'h5555);
        chk("both_low", low, 1);

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache controller for the 16-bit pipelined MIPS. It is the memory-side responder to the EX/MEM pipeline register: it consumes the registered address, store data and MemRead/MemWrite strobes, and returns load data plus the `hit` signal that freezes the pipeline registers while a miss fill or write-through is outstanding. It sits between EX/MEM and the multi-cycle main data memory.

## Interface
- `LINES`, 8: number of cache lines (power of two).
- `WORDS`, 4: 16-bit words per line (power of two).
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `addr_in` in 16: word address, from EX/MEM ALU result.
- `wdata_in` in 16: store data, from EX/MEM read-data-2.
- `MemRead_in` in 1: load request.
- `MemWrite_in` in 1: store request.
- `hit_out` out 1: 1 = request satisfied this cycle, pipeline may advance; 0 = stall.
- `rdata_out` out 16: load data, valid when `MemRead_in && hit_out`, else 0.
- `mem_req` out 1: main-memory request, held until `mem_ack`.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out 16: main-memory word address.
- `mem_wdata` out 16: main-memory write data.
- `mem_rdata` in 16: main-memory read data, valid with `mem_ack`.
- `mem_ack` in 1: one-cycle completion pulse for the current access.

## Operation
- Address split: offset = low log2(WORDS) bits, index = next log2(LINES) bits, tag = remaining bits (defaults: [1:0], [4:2], [15:5]).
- Per line: valid bit, tag, WORDS data words.
- States: IDLE, FILL, WRITE.
- IDLE, no request: `hit_out`=1, `mem_req`=0.
- IDLE, MemWrite_in (priority over MemRead_in if both set): `hit_out`=0, next state WRITE.
- IDLE, MemRead_in, valid and tag match: `hit_out`=1, `rdata_out` = cached word, combinational; stay IDLE.
- IDLE, MemRead_in, miss: `hit_out`=0, clear word counter, next state FILL.
- FILL: `mem_req`=1, `mem_we`=0, `mem_addr` = {tag, index, counter}. On `mem_ack`, store `mem_rdata` into word[counter] and increment counter. On the ack for word WORDS-1, set valid, write tag, go to IDLE. `hit_out`=0 throughout; the following IDLE cycle hits.
- WRITE: `mem_req`=1, `mem_we`=1, `mem_addr`=`addr_in`, `mem_wdata`=`wdata_in`. On `mem_ack`, set `hit_out`=1 in that same cycle, update the cached word if the line is valid and the tag matches (no allocate on miss), and go to IDLE.
- `mem_ack` in IDLE is ignored.
- Counter width is log2(WORDS); it wraps to 0 after the last word.

## Timing
- Reset (posedge with `rst`=1): state IDLE, all valid bits cleared, counter 0. `mem_req`/`mem_we`=0, `mem_addr`/`mem_wdata`=0 while IDLE, and `rdata_out`=0. Tag and data arrays are not reset.
- Reset mid-FILL: the partially filled line stays invalid and `mem_req` drops on the next cycle. Reset mid-WRITE: the write is abandoned, and the memory must tolerate the dropped request.
- Read hit: 0 stall cycles.
- Read miss: WORDS acks, then 1 IDLE cycle (minimum WORDS+1 cycles with single-cycle memory).
- Write: stall until `mem_ack`, with `hit_out` asserted in the ack cycle.
- EX/MEM samples `hit_out` on negedge, so new request inputs are stable by the next posedge.
- `mem_req` stays high continuously across fill words. Address advances the cycle after each ack.

## Structure
- Package `dcache_pkg`: state enum, and functions or localparams for offset, index and tag widths derived from LINES/WORDS.
- Sub-module `dcache_line_ram`: valid, tag and data storage with combinational read port, a synchronous single-word write port and a valid clear on `rst`.
- The controller FSM, counter and hit logic live in `dcache_ctrl`.

## Test plan
- Reset, then Read 0x0040 with memory returning 0xA0..0xA3 for 0x0040..0x0043 at 1-cycle ack -> `hit_out` low 5 cycles, `mem_addr` 0x0040..0x0043, then `rdata_out`=0xA0. A following Read 0x0042 -> hit in 0 cycles, data 0xA2.
- Write 0x0041 data 0x1234 after the fill above, ack delayed 3 cycles -> `mem_we`=1, `hit_out` low 3 cycles then high on the ack cycle. A following Read 0x0041 -> 0x1234 with no `mem_req`.
- Write 0x0100 to an uncached line, then Read 0x0100 -> write-through only, with no fill on the write. The read then misses and fills 0x0100..0x0103.
- Conflict test: Read 0x0040, then Read 0x0060 (same index, tag differs), then Read 0x0040 -> three full fills, each returning the correct memory contents.
- `rst` asserted after the 2nd fill ack of a miss at 0x0080 -> `mem_req`=0 the next cycle. A later Read 0x0080 performs a full 4-word fill.
- MemRead_in and MemWrite_in both set at 0x0010 -> treated as a write (`mem_we`=1) and no fill.
